alu_ctrl_muldiv: RTL
====================

// Module: alu_ctrl_muldiv
// PURPOSE
//  Second-generation EX-stage ALU control: decodes ALUOp/funct to a 4-bit ALU code for the single-cycle ALU,
//  and adds an iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers (MFHI/MFLO/MTHI/MTLO).
//  Sits between the ID/EX register and the ALU; uses a valid/ready handshake to stall the pipeline while busy.
// PARAMETERS
//  WIDTH      32  operand/HI/LO width; WIDTH >= 4
//  MULDIV_EN  1   0: mul/div/HI/LO funct codes decode as illegal (illegal=1, no state change)
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      instruction presented
//  in_ready   out  1      block can accept; transfer on in_valid & in_ready
//  alu_op     in   2      00 add(lw/sw), 01 sub(beq), 10 R-type, 11 reserved
//  funct      in   6      R-type funct field
//  src_a      in   WIDTH  rs operand
//  src_b      in   WIDTH  rt operand
//  cancel     in   1      kill in-flight mul/div (branch flush)
//  alu_con    out  4      registered ALU code
//  alu_valid  out  1      1-cycle pulse: alu_con is valid for the accepted instruction
//  mf_data    out  WIDTH  MFHI/MFLO result
//  mf_valid   out  1      1-cycle pulse: mf_data valid
//  busy       out  1      mul/div engine running
//  div_zero   out  1      1-cycle pulse: DIV/DIVU with src_b==0
//  illegal    out  1      1-cycle pulse: alu_op 11 or unknown R-type funct
//  hi, lo     out  WIDTH  architectural HI/LO
// BEHAVIOUR
//  Reset: all outputs 0, hi=lo=0, state IDLE, in_ready=1 the cycle after reset deasserts.
//  Decode (registered, latency 1 after accept): 00->0010, 01->0110; R-type: 100000/100001->0010,
//   100010/100011->0110, 100100->0000, 100101->0001, 100110->0011, 100111->1100, 101010->0111, 101011->1000.
//   Unknown funct or alu_op 11 -> alu_con=0000, alu_valid=0, illegal=1.
//  in_ready = (state==IDLE) & ~reset. alu_valid/mf_valid/div_zero/illegal are 0 when no accept occurred.
//  MFHI 010000 / MFLO 010010: mf_data<=hi/lo, mf_valid=1 next cycle. MTHI 010001 / MTLO 010011: hi/lo<=src_a next cycle.
//  States IDLE->MUL|DIV (accept of 011000/011001 or 011010/011011) -> FIX -> IDLE.
//   MUL/DIV last exactly WIDTH cycles (one shift-add / restoring-subtract bit per cycle); FIX is 1 cycle.
//   busy=1 for WIDTH+1 cycles; hi/lo updated at the FIX->IDLE edge; in_ready=1 that next cycle.
//  Signed ops: operate on magnitudes; FIX negates product if signs differ; quotient negative if signs differ,
//   remainder takes dividend sign. MULT: {hi,lo}=2*WIDTH-bit product. DIV: lo=quotient, hi=remainder.
//  Most-negative / -1 (signed div): lo=most-negative, hi=0 (natural result of magnitude algorithm).
//  Divide by zero: no iteration; div_zero=1 next cycle, hi/lo unchanged, state stays IDLE.
//  cancel: in MUL/DIV/FIX -> IDLE next cycle, hi/lo unchanged, busy=0. cancel in IDLE with an accept in the
//   same cycle drops that instruction (no outputs, no state change). Reset mid-op behaves as reset.
//  Non-mul/div ops in IDLE never affect the engine; accepts are back-to-back at 1/cycle.
// STRUCTURE
//  alu_ctrl_pkg: ALUCon code constants, ALUOp codes, funct codes, state enum (IDLE/MUL/DIV/FIX).
//  Sub-module muldiv_seq: iterative engine (operand regs, WIDTH-cycle counter, accumulator, sign fix);
//   top holds decode, handshake, HI/LO, pulse outputs.
// TESTING
//  1 alu_op=10 funct=100111, in_valid 1 cycle -> next cycle alu_con=1100, alu_valid=1; following cycle pulse 0.
//  2 MULT a=-3 b=7 (WIDTH=32) -> busy 33 cycles, then hi=FFFFFFFF lo=FFFFFFEB; MFLO -> mf_data=FFFFFFEB.
//  3 DIV a=-7 b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); DIVU a=7 b=0 -> div_zero pulse, hi/lo unchanged, busy 0.
//  4 MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001; in_valid held during busy -> no accept until idle.
//  5 cancel at cycle 10 of DIVU -> busy=0 next cycle, hi/lo keep prior values; reset during MUL -> all outputs 0.
//  6 alu_op=11 and funct=111111 -> illegal pulse, alu_con=0000; MULDIV_EN=0 with funct 011000 -> illegal, busy 0.

Source files
------------

// File: rtl/alu_ctrl_muldiv_pkg.sv
// rtl/alu_ctrl_muldiv_pkg.sv - ALU control codes, opcodes, funct codes and engine state
package alu_ctrl_muldiv_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  typedef enum logic [2:0] {
    CL_ALU, CL_MFHI, CL_MFLO, CL_MTHI, CL_MTLO, CL_MUL, CL_DIV, CL_ILL
  } op_class_t;

  // Returns {hit, alu code} for the single-cycle R-type ALU functs.
  function automatic logic [4:0] rtype_alu(input logic [5:0] f);
    logic [4:0] r;
    r = '0;
    case (f)
      F_ADD, F_ADDU: r = {1'b1, ALU_ADD};
      F_SUB, F_SUBU: r = {1'b1, ALU_SUB};
      F_AND:         r = {1'b1, ALU_AND};
      F_OR:          r = {1'b1, ALU_OR};
      F_XOR:         r = {1'b1, ALU_XOR};
      F_NOR:         r = {1'b1, ALU_NOR};
      F_SLT:         r = {1'b1, ALU_SLT};
      F_SLTU:        r = {1'b1, ALU_SLTU};
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// rtl/alu_ctrl_muldiv_if.sv - ID/EX side bundle for the ALU control and mul/div block
interface alu_ctrl_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic [3:0]       alu_con;
  logic             alu_valid;
  logic [WIDTH-1:0] mf_data;
  logic             mf_valid;
  logic             busy;
  logic             div_zero;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, alu_op, funct, src_a, src_b, cancel,
    input  in_ready, alu_con, alu_valid, mf_data, mf_valid, busy, div_zero, illegal, hi, lo
  );

  modport slave (
    input  in_valid, alu_op, funct, src_a, src_b, cancel,
    output in_ready, alu_con, alu_valid, mf_data, mf_valid, busy, div_zero, illegal, hi, lo
  );
endinterface

// File: rtl/alu_ctrl_muldiv_muldiv_seq.sv
// rtl/alu_ctrl_muldiv_muldiv_seq.sv - iterative shift-add multiplier / restoring divider
module muldiv_seq
  import alu_ctrl_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             idle,
  output logic             busy,
  output logic             fix,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic             neg_q;
  logic             neg_r;
  logic             div_op;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0] quo_neg, rem_neg;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // acc_hi holds the partial product (mul) or partial remainder (div);
  // acc_lo shifts out multiplier bits or shifts in quotient bits.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  assign prod     = {acc_hi, acc_lo};
  assign prod_neg = ~prod + 1'b1;
  assign quo_neg  = ~acc_lo + 1'b1;
  assign rem_neg  = ~acc_hi + 1'b1;

  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (div_op) begin
      res_lo = neg_q ? quo_neg : acc_lo;
      res_hi = neg_r ? rem_neg : acc_hi;
    end else if (neg_q) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
  end

  assign idle = (state == ST_IDLE);
  assign fix  = (state == ST_FIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div_op <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= is_div ? ST_DIV : ST_MUL;
            busy   <= 1'b1;
            cnt    <= CW'(WIDTH - 1);
            acc_hi <= '0;
            acc_lo <= a_mag;
            opb    <= b_mag;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div_op <= is_div;
          end
        end
        ST_MUL: begin
          if (cancel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            cnt    <= cnt - 1'b1;
            if (cnt == '0) state <= ST_FIX;
          end
        end
        ST_DIV: begin
          if (cancel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// rtl/alu_ctrl_muldiv.sv - EX-stage ALU control decode with HI/LO and iterative mul/div
module alu_ctrl_muldiv
  import alu_ctrl_muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  alu_ctrl_muldiv_if.slave bus
);
  logic             eng_idle;
  logic             eng_fix;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             accept;
  logic             b_zero;
  logic             start;
  logic [4:0]       rt_hit;
  op_class_t        cls;
  logic [3:0]       code;

  assign bus.in_ready = eng_idle & ~reset;
  // A cancel coinciding with an accept squashes the instruction entirely.
  assign accept = bus.in_valid & bus.in_ready & ~bus.cancel;
  assign b_zero = (bus.src_b == '0);

  always_comb begin
    rt_hit = rtype_alu(bus.funct);
    cls    = CL_ILL;
    code   = ALU_AND;
    case (bus.alu_op)
      OP_ADD: begin
        cls  = CL_ALU;
        code = ALU_ADD;
      end
      OP_SUB: begin
        cls  = CL_ALU;
        code = ALU_SUB;
      end
      OP_RTYPE: begin
        if (rt_hit[4]) begin
          cls  = CL_ALU;
          code = rt_hit[3:0];
        end else if (MULDIV_EN) begin
          case (bus.funct)
            F_MFHI:          cls = CL_MFHI;
            F_MFLO:          cls = CL_MFLO;
            F_MTHI:          cls = CL_MTHI;
            F_MTLO:          cls = CL_MTLO;
            F_MULT, F_MULTU: cls = CL_MUL;
            F_DIV, F_DIVU:   cls = CL_DIV;
            default:         cls = CL_ILL;
          endcase
        end
      end
      default: cls = CL_ILL;
    endcase
  end

  assign start = accept & ((cls == CL_MUL) | ((cls == CL_DIV) & ~b_zero));

  muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_div    (cls == CL_DIV),
    .is_signed (~bus.funct[0]),
    .cancel    (bus.cancel),
    .a         (bus.src_a),
    .b         (bus.src_b),
    .idle      (eng_idle),
    .busy      (bus.busy),
    .fix       (eng_fix),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alu_con   <= '0;
      bus.alu_valid <= 1'b0;
      bus.mf_data   <= '0;
      bus.mf_valid  <= 1'b0;
      bus.div_zero  <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.hi        <= '0;
      bus.lo        <= '0;
    end else begin
      bus.alu_valid <= 1'b0;
      bus.mf_valid  <= 1'b0;
      bus.div_zero  <= 1'b0;
      bus.illegal   <= 1'b0;
      if (eng_fix && !bus.cancel) begin
        bus.hi <= res_hi;
        bus.lo <= res_lo;
      end
      if (accept) begin
        bus.alu_con <= (cls == CL_ALU) ? code : ALU_AND;
        case (cls)
          CL_ALU:  bus.alu_valid <= 1'b1;
          CL_MFHI: begin
            bus.mf_data  <= bus.hi;
            bus.mf_valid <= 1'b1;
          end
          CL_MFLO: begin
            bus.mf_data  <= bus.lo;
            bus.mf_valid <= 1'b1;
          end
          CL_MTHI: bus.hi <= bus.src_a;
          CL_MTLO: bus.lo <= bus.src_a;
          CL_DIV:  bus.div_zero <= b_zero;
          CL_ILL:  bus.illegal <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
